rvfpm_xif_initiator: RTL and testbench
======================================

RVFPM_XIF_INITIATOR -- requirements
Module: rvfpm_xif_initiator

Interface
REQ-001 Parameter X_ID_WIDTH, default 4, width of the instruction ID on the issue, commit and result channels.
REQ-002 Parameter XLEN, default 32, width of the operand and result data.
REQ-003 Parameter MAX_OUTSTANDING, default 4, maximum number of accepted, uncompleted instructions; range 1..2^X_ID_WIDTH.
REQ-004 ck  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  command handshake from the stimulus source.
REQ-007 cmd_instr, cmd_rs1, cmd_kill  in  32, XLEN, 1  instruction word, operand, and commit-kill request for this command.
REQ-008 x_issue_valid / x_issue_ready  out / in  1 / 1  issue handshake toward the FPU.
REQ-009 x_issue_instr, x_issue_rs1, x_issue_id  out  32, XLEN, X_ID_WIDTH  issued instruction word, operand and ID.
REQ-010 x_issue_accept  in  1  FPU accepts the instruction; sampled on the issue handshake cycle.
REQ-011 x_commit_valid, x_commit_id, x_commit_kill  out  1, X_ID_WIDTH, 1  single-cycle commit pulse.
REQ-012 x_result_valid / x_result_ready  in / out  1 / 1  result handshake; x_result_ready equals rsp_ready.
REQ-013 x_result_id, x_result_data, x_result_we  in  X_ID_WIDTH, XLEN, 1  result payload.
REQ-014 rsp_ready  in  1  downstream back-pressure on results.
REQ-015 rsp_valid, rsp_id, rsp_data, rsp_we  out  1, X_ID_WIDTH, XLEN, 1  results forwarded to downstream.
REQ-016 outstanding_cnt, rejected_cnt, err_cnt  out  X_ID_WIDTH+1, 16, 16  status and error counters.

Function
REQ-017 The FSM SHALL have three states: IDLE, ISSUE and COMMIT.
REQ-018 IDLE: cmd_ready=1 iff outstanding_cnt<MAX_OUTSTANDING and the next ID is free; on cmd_valid&&cmd_ready, capture instr, rs1, kill and the next ID, then go to ISSUE.
REQ-019 ISSUE: x_issue_valid=1 and the payload SHALL be held stable until x_issue_ready=1.
REQ-020 ISSUE exit, accept=1: mark the ID outstanding and go to COMMIT.
REQ-021 ISSUE exit, accept=0: free the ID, increment rejected_cnt (saturating) and return to IDLE; no commit is sent.
REQ-022 COMMIT: x_commit_valid=1 for exactly one cycle with the captured ID and kill, then return to IDLE.
REQ-023 Kill: a killed ID SHALL be freed at commit, and its later result SHALL be dropped silently, with no rsp_valid and no error.
REQ-024 Commit-to-issue latency: minimum one command every 3 cycles (IDLE, ISSUE, COMMIT).
REQ-025 ID generation: a counter incrementing modulo 2^X_ID_WIDTH after each issue handshake; if the next ID is still in use, cmd_ready=0 until it is freed.
REQ-026 Result forwarding, matching ID: on x_result_valid&&x_result_ready with an outstanding, non-killed ID, drive rsp_* combinationally from x_result_*, free the ID and decrement outstanding_cnt.
REQ-027 Result forwarding, unknown ID: if the ID is not outstanding, increment err_cnt (saturating) and assert no rsp_valid.
REQ-028 Same-cycle result and issue accept: outstanding_cnt changes by net zero.
REQ-029 Same-cycle result and accept on the same ID is impossible, because the ID is still in use.
REQ-030 Results SHALL be accepted in any order; no reordering is performed.

Reset
REQ-031 Asserting rst (low) SHALL immediately clear the state to IDLE, the ID counter to 0, the in-use mask, all counters and every valid output; x_result_ready follows rsp_ready.
REQ-032 A reset mid-ISSUE or mid-COMMIT SHALL abandon the transaction, with no commit after reset is released.

Structure
REQ-033 The FSM state enum and the MAX_OUTSTANDING and X_ID_WIDTH defaults SHALL live in the shared package rvfpm_xif_pkg.
REQ-034 The in-use mask and ID allocator SHALL be one sub-module, rvfpm_xif_id_tracker (alloc, free, in_use query, count).

Verification
REQ-035 Single issue: cmd instr=0x0020F0D3, rs1=0x3F800000, accept=1, ready=1 -> issue in cycle 1, commit id=0 kill=0 in cycle 2; result id=0 data=0x40000000 -> rsp_valid same cycle, outstanding_cnt 1->0.
REQ-036 Reject: accept=0 -> no commit, rejected_cnt=1, the next command reuses a free ID and is issued as id=1.
REQ-037 Full: 4 accepted commands with no results -> cmd_ready=0 with outstanding_cnt=4; one result id=2 -> cmd_ready=1 next cycle.
REQ-038 Kill: cmd_kill=1 -> commit kill=1; a later result with that ID -> no rsp_valid, err_cnt unchanged.
REQ-039 Unknown ID: result id=7 with nothing outstanding -> err_cnt=1, no rsp_valid.
REQ-040 Reset: assert rst during ISSUE with x_issue_ready=0 -> x_issue_valid=0 immediately; after release, no commit and all counters are 0.

Source files
------------

// File: rtl/rvfpm_xif_pkg.sv
// Shared definitions for the rvfpm X-interface initiator.
//   - fsm_state_e        : initiator FSM state encoding (IDLE, ISSUE, COMMIT)
//   - X_ID_WIDTH_DEF     : default instruction-ID width
//   - MAX_OUTSTANDING_DEF: default limit on accepted, uncompleted instructions
//   - sat_inc16()        : saturating increment for 16-bit status counters
package rvfpm_xif_pkg;

    localparam int unsigned X_ID_WIDTH_DEF      = 4;
    localparam int unsigned MAX_OUTSTANDING_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_COMMIT = 2'd2
    } fsm_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rvfpm_xif_id_tracker.sv
// In-use mask and outstanding counter for X-interface instruction IDs.
// Ports:
//   i_ck, i_rst            clock, asynchronous active-low reset
//   i_alloc/i_alloc_id     reserve an ID (set its in-use bit)
//   i_inc                  one more accepted instruction outstanding
//   i_free_a/_id/_dec      release an ID; _dec also drops the outstanding count
//   i_free_b/_id/_dec      second release port (results), same semantics
//   i_qa_id/o_qa_busy      in-use query A
//   i_qb_id/o_qb_busy      in-use query B
//   o_count                number of accepted, uncompleted instructions
module rvfpm_xif_id_tracker
    import rvfpm_xif_pkg::*;
#(
    parameter int unsigned ID_W = X_ID_WIDTH_DEF
)(
    input  logic            i_ck,
    input  logic            i_rst,
    input  logic            i_alloc,
    input  logic [ID_W-1:0] i_alloc_id,
    input  logic            i_inc,
    input  logic            i_free_a,
    input  logic [ID_W-1:0] i_free_a_id,
    input  logic            i_free_a_dec,
    input  logic            i_free_b,
    input  logic [ID_W-1:0] i_free_b_id,
    input  logic            i_free_b_dec,
    input  logic [ID_W-1:0] i_qa_id,
    output logic            o_qa_busy,
    input  logic [ID_W-1:0] i_qb_id,
    output logic            o_qb_busy,
    output logic [ID_W:0]   o_count
);

    localparam int unsigned    NID     = 1 << ID_W;
    localparam logic [ID_W:0]  CNT_ONE = {{ID_W{1'b0}}, 1'b1};

    logic [NID-1:0] r_mask;
    logic [NID-1:0] w_mask_nxt;
    logic [ID_W:0]  r_cnt;
    logic [ID_W:0]  w_cnt_nxt;

    always_comb begin
        w_mask_nxt = r_mask;
        if (i_free_a) w_mask_nxt[i_free_a_id] = 1'b0;
        if (i_free_b) w_mask_nxt[i_free_b_id] = 1'b0;
        // Allocation only targets a free ID, so it never collides with a release.
        if (i_alloc)  w_mask_nxt[i_alloc_id]  = 1'b1;
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_inc)                     w_cnt_nxt = w_cnt_nxt + CNT_ONE;
        if (i_free_a && i_free_a_dec)  w_cnt_nxt = w_cnt_nxt - CNT_ONE;
        if (i_free_b && i_free_b_dec)  w_cnt_nxt = w_cnt_nxt - CNT_ONE;
    end

    always_ff @(posedge i_ck or negedge i_rst) begin
        if (!i_rst) begin
            r_mask <= '0;
            r_cnt  <= '0;
        end else begin
            r_mask <= w_mask_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign o_qa_busy = r_mask[i_qa_id];
    assign o_qb_busy = r_mask[i_qb_id];
    assign o_count   = r_cnt;

endmodule

// File: rtl/rvfpm_xif_initiator.sv
// X-interface initiator: takes commands from a stimulus source, issues them to
// an FPU, sends a one-cycle commit, and forwards FPU results downstream.
// Ports:
//   ck, rst                          clock, asynchronous active-low reset
//   cmd_*                            command handshake + instr/rs1/kill payload
//   x_issue_*                        issue channel toward the FPU
//   x_commit_*                       single-cycle commit pulse
//   x_result_*                       result channel from the FPU
//   rsp_*                            results forwarded downstream
//   outstanding_cnt/rejected_cnt/err_cnt  status counters
module rvfpm_xif_initiator
    import rvfpm_xif_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH      = X_ID_WIDTH_DEF,
    parameter int unsigned XLEN            = 32,
    parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
)(
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [31:0]           cmd_instr,
    input  logic [XLEN-1:0]       cmd_rs1,
    input  logic                  cmd_kill,
    output logic                  x_issue_valid,
    input  logic                  x_issue_ready,
    output logic [31:0]           x_issue_instr,
    output logic [XLEN-1:0]       x_issue_rs1,
    output logic [X_ID_WIDTH-1:0] x_issue_id,
    input  logic                  x_issue_accept,
    output logic                  x_commit_valid,
    output logic [X_ID_WIDTH-1:0] x_commit_id,
    output logic                  x_commit_kill,
    input  logic                  x_result_valid,
    output logic                  x_result_ready,
    input  logic [X_ID_WIDTH-1:0] x_result_id,
    input  logic [XLEN-1:0]       x_result_data,
    input  logic                  x_result_we,
    input  logic                  rsp_ready,
    output logic                  rsp_valid,
    output logic [X_ID_WIDTH-1:0] rsp_id,
    output logic [XLEN-1:0]       rsp_data,
    output logic                  rsp_we,
    output logic [X_ID_WIDTH:0]   outstanding_cnt,
    output logic [15:0]           rejected_cnt,
    output logic [15:0]           err_cnt
);

    localparam int unsigned          NID     = 1 << X_ID_WIDTH;
    localparam logic [X_ID_WIDTH:0]  MAX_CNT = (X_ID_WIDTH+1)'(MAX_OUTSTANDING);

    fsm_state_e             r_state;
    logic [31:0]            r_instr;
    logic [XLEN-1:0]        r_rs1;
    logic                   r_kill;
    logic [X_ID_WIDTH-1:0]  r_id;
    logic [X_ID_WIDTH-1:0]  r_next_id;
    logic [NID-1:0]         r_killed;
    logic [NID-1:0]         w_killed_nxt;
    logic [15:0]            r_rej;
    logic [15:0]            r_err;

    logic                   w_next_busy;
    logic                   w_res_busy;
    logic [X_ID_WIDTH:0]    w_cnt;
    logic                   w_cmd_fire;
    logic                   w_iss_fire;
    logic                   w_acc;
    logic                   w_rej;
    logic                   w_commit;
    logic                   w_commit_kill;
    logic                   w_res_fire;
    logic                   w_res_pending;
    logic                   w_res_kill_now;
    logic                   w_res_killed;
    logic                   w_res_known;
    logic                   w_res_fwd;

    assign cmd_ready     = (r_state == ST_IDLE) && (w_cnt < MAX_CNT) && !w_next_busy;
    assign w_cmd_fire    = cmd_valid && cmd_ready;
    assign w_iss_fire    = (r_state == ST_ISSUE) && x_issue_ready;
    assign w_acc         = w_iss_fire && x_issue_accept;
    assign w_rej         = w_iss_fire && !x_issue_accept;
    assign w_commit      = (r_state == ST_COMMIT);
    assign w_commit_kill = w_commit && r_kill;

    // Result classification. The ID held in ISSUE is reserved but not yet
    // accepted, so a result naming it counts as unknown. A result arriving in
    // the very cycle its ID is being killed is treated as already killed.
    assign w_res_fire     = x_result_valid && rsp_ready;
    assign w_res_pending  = (r_state == ST_ISSUE) && (x_result_id == r_id);
    assign w_res_kill_now = w_commit_kill && (x_result_id == r_id);
    assign w_res_killed   = r_killed[x_result_id] || w_res_kill_now;
    assign w_res_known    = w_res_busy && !w_res_pending;
    assign w_res_fwd      = w_res_known && !w_res_killed;

    rvfpm_xif_id_tracker #(
        .ID_W (X_ID_WIDTH)
    ) u_ids (
        .i_ck         (ck),
        .i_rst        (rst),
        .i_alloc      (w_cmd_fire),
        .i_alloc_id   (r_next_id),
        .i_inc        (w_acc),
        .i_free_a     (w_rej || w_commit_kill),
        .i_free_a_id  (r_id),
        .i_free_a_dec (w_commit_kill),
        .i_free_b     (w_res_fire && w_res_fwd),
        .i_free_b_id  (x_result_id),
        .i_free_b_dec (1'b1),
        .i_qa_id      (r_next_id),
        .o_qa_busy    (w_next_busy),
        .i_qb_id      (x_result_id),
        .o_qb_busy    (w_res_busy),
        .o_count      (w_cnt)
    );

    // Killed IDs are already freed; this mask only lets their late result be
    // swallowed silently instead of being counted as an error.
    always_comb begin
        w_killed_nxt = r_killed;
        if (w_res_fire && r_killed[x_result_id])
            w_killed_nxt[x_result_id] = 1'b0;
        if (w_commit_kill && !(w_res_fire && w_res_kill_now))
            w_killed_nxt[r_id] = 1'b1;
        if (w_cmd_fire)
            w_killed_nxt[r_next_id] = 1'b0;
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_instr   <= '0;
            r_rs1     <= '0;
            r_kill    <= 1'b0;
            r_id      <= '0;
            r_next_id <= '0;
            r_killed  <= '0;
            r_rej     <= '0;
            r_err     <= '0;
        end else begin
            r_killed <= w_killed_nxt;
            if (w_res_fire && !w_res_known && !w_res_killed)
                r_err <= sat_inc16(r_err);
            unique case (r_state)
                ST_IDLE: begin
                    if (w_cmd_fire) begin
                        r_instr <= cmd_instr;
                        r_rs1   <= cmd_rs1;
                        r_kill  <= cmd_kill;
                        r_id    <= r_next_id;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_iss_fire) begin
                        r_next_id <= r_next_id + 1'b1;
                        if (x_issue_accept) begin
                            r_state <= ST_COMMIT;
                        end else begin
                            r_rej   <= sat_inc16(r_rej);
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_COMMIT: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign x_issue_valid   = (r_state == ST_ISSUE);
    assign x_issue_instr   = r_instr;
    assign x_issue_rs1     = r_rs1;
    assign x_issue_id      = r_id;
    assign x_commit_valid  = w_commit;
    assign x_commit_id     = r_id;
    assign x_commit_kill   = r_kill;
    assign x_result_ready  = rsp_ready;
    assign rsp_valid       = x_result_valid && w_res_fwd;
    assign rsp_id          = x_result_id;
    assign rsp_data        = x_result_data;
    assign rsp_we          = x_result_we;
    assign outstanding_cnt = w_cnt;
    assign rejected_cnt    = r_rej;
    assign err_cnt         = r_err;

endmodule

// File: tb/tb_rvfpm_xif_initiator.sv
module tb_rvfpm_xif_initiator;

    logic        ck = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_kill;
    logic [31:0] cmd_instr, cmd_rs1;
    logic        x_issue_valid, x_issue_ready, x_issue_accept;
    logic [31:0] x_issue_instr, x_issue_rs1;
    logic [3:0]  x_issue_id;
    logic        x_commit_valid, x_commit_kill;
    logic [3:0]  x_commit_id;
    logic        x_result_valid, x_result_ready, x_result_we;
    logic [3:0]  x_result_id;
    logic [31:0] x_result_data;
    logic        rsp_ready, rsp_valid, rsp_we;
    logic [3:0]  rsp_id;
    logic [31:0] rsp_data;
    logic [4:0]  outstanding_cnt;
    logic [15:0] rejected_cnt, err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 ck = ~ck;

    rvfpm_xif_initiator #(
        .X_ID_WIDTH      (4),
        .XLEN            (32),
        .MAX_OUTSTANDING (4)
    ) dut (
        .ck              (ck),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_instr       (cmd_instr),
        .cmd_rs1         (cmd_rs1),
        .cmd_kill        (cmd_kill),
        .x_issue_valid   (x_issue_valid),
        .x_issue_ready   (x_issue_ready),
        .x_issue_instr   (x_issue_instr),
        .x_issue_rs1     (x_issue_rs1),
        .x_issue_id      (x_issue_id),
        .x_issue_accept  (x_issue_accept),
        .x_commit_valid  (x_commit_valid),
        .x_commit_id     (x_commit_id),
        .x_commit_kill   (x_commit_kill),
        .x_result_valid  (x_result_valid),
        .x_result_ready  (x_result_ready),
        .x_result_id     (x_result_id),
        .x_result_data   (x_result_data),
        .x_result_we     (x_result_we),
        .rsp_ready       (rsp_ready),
        .rsp_valid       (rsp_valid),
        .rsp_id          (rsp_id),
        .rsp_data        (rsp_data),
        .rsp_we          (rsp_we),
        .outstanding_cnt (outstanding_cnt),
        .rejected_cnt    (rejected_cnt),
        .err_cnt         (err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ck);
        #2;
    endtask

    initial begin
        logic [3:0] drain_ids [3];
        drain_ids = '{4'd6, 4'd3, 4'd4};

        rst = 1'b0;
        cmd_valid = 1'b0; cmd_kill = 1'b0; cmd_instr = '0; cmd_rs1 = '0;
        x_issue_ready = 1'b1; x_issue_accept = 1'b1;
        x_result_valid = 1'b0; x_result_id = '0; x_result_data = '0; x_result_we = 1'b0;
        rsp_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_issue_valid", x_issue_valid, 0);
        chk("rst_commit_valid", x_commit_valid, 0);
        chk("rst_outstanding", outstanding_cnt, 0);
        chk("rst_rejected", rejected_cnt, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_result_ready", x_result_ready, 1);
        rsp_ready = 1'b0;
        #1 chk("result_ready_follows", x_result_ready, 0);
        rsp_ready = 1'b1;
        rst = 1'b1;

        // Single issue, commit, result
        cmd_valid = 1'b1; cmd_instr = 32'h0020F0D3; cmd_rs1 = 32'h3F800000;
        #1 chk("single_cmd_ready", cmd_ready, 1);
        cyc();
        cmd_valid = 1'b0;
        chk("single_issue_valid", x_issue_valid, 1);
        chk("single_issue_instr", x_issue_instr, 32'h0020F0D3);
        chk("single_issue_rs1", x_issue_rs1, 32'h3F800000);
        chk("single_issue_id", x_issue_id, 0);
        cyc();
        chk("single_commit_valid", x_commit_valid, 1);
        chk("single_commit_id", x_commit_id, 0);
        chk("single_commit_kill", x_commit_kill, 0);
        chk("single_outstanding1", outstanding_cnt, 1);
        cyc();
        chk("single_commit_pulse", x_commit_valid, 0);
        x_result_valid = 1'b1; x_result_id = 4'd0; x_result_data = 32'h40000000; x_result_we = 1'b1;
        #1;
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_data", rsp_data, 32'h40000000);
        chk("single_rsp_id", rsp_id, 0);
        cyc();
        x_result_valid = 1'b0;
        chk("single_outstanding0", outstanding_cnt, 0);

        // Reset while ISSUE is stalled
        cmd_valid = 1'b1; cmd_instr = 32'h12345678; x_issue_ready = 1'b0;
        cyc();
        cmd_valid = 1'b0;
        chk("stall_issue_valid", x_issue_valid, 1);
        chk("stall_issue_id", x_issue_id, 1);
        cyc();
        chk("stall_hold_valid", x_issue_valid, 1);
        chk("stall_hold_instr", x_issue_instr, 32'h12345678);
        rst = 1'b0;
        #1 chk("midrst_issue_valid", x_issue_valid, 0);
        cyc();
        rst = 1'b1; x_issue_ready = 1'b1; x_issue_accept = 1'b1;
        cyc();
        chk("postrst_commit0", x_commit_valid, 0);
        chk("postrst_issue0", x_issue_valid, 0);
        cyc();
        chk("postrst_commit1", x_commit_valid, 0);
        chk("postrst_outstanding", outstanding_cnt, 0);
        chk("postrst_rejected", rejected_cnt, 0);
        chk("postrst_err", err_cnt, 0);

        // Reject, then the following command uses the next ID
        cmd_valid = 1'b1; cmd_instr = 32'hAAAA0001; x_issue_accept = 1'b0;
        #1 chk("rej_cmd_ready", cmd_ready, 1);
        cyc();
        cmd_valid = 1'b0;
        chk("rej_issue_id", x_issue_id, 0);
        cyc();
        chk("rej_no_commit", x_commit_valid, 0);
        chk("rej_count", rejected_cnt, 1);
        chk("rej_outstanding", outstanding_cnt, 0);
        cmd_valid = 1'b1; x_issue_accept = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        chk("after_rej_issue_id", x_issue_id, 1);
        cyc();
        chk("after_rej_commit_id", x_commit_id, 1);
        cyc();
        chk("after_rej_outstanding", outstanding_cnt, 1);

        // Fill to the outstanding limit with IDs 2, 3, 4
        for (int k = 0; k < 3; k++) begin
            cmd_valid = 1'b1;
            cyc();
            cmd_valid = 1'b0;
            chk("fill_issue_id", x_issue_id, 64'(k + 2));
            cyc();
            cyc();
        end
        chk("full_outstanding", outstanding_cnt, 4);
        cmd_valid = 1'b1;
        #1 chk("full_cmd_ready", cmd_ready, 0);
        x_result_valid = 1'b1; x_result_id = 4'd2; x_result_data = 32'h00000222;
        #1;
        chk("full_rsp_valid", rsp_valid, 1);
        chk("full_cmd_ready_same", cmd_ready, 0);
        cyc();
        x_result_valid = 1'b0; cmd_kill = 1'b1;
        #1;
        chk("full_cmd_ready_next", cmd_ready, 1);
        chk("full_outstanding3", outstanding_cnt, 3);

        // Killed command (ID 5)
        cyc();
        cmd_valid = 1'b0; cmd_kill = 1'b0;
        chk("kill_issue_id", x_issue_id, 5);
        cyc();
        chk("kill_commit_valid", x_commit_valid, 1);
        chk("kill_commit_kill", x_commit_kill, 1);
        chk("kill_commit_id", x_commit_id, 5);
        cyc();
        chk("kill_outstanding", outstanding_cnt, 3);
        x_result_valid = 1'b1; x_result_id = 4'd5; x_result_data = 32'h00000555;
        #1 chk("kill_rsp_valid", rsp_valid, 0);
        cyc();
        x_result_valid = 1'b0;
        chk("kill_err", err_cnt, 0);
        chk("kill_outstanding_after", outstanding_cnt, 3);

        // Result retires in the same cycle a new command is accepted (ID 6)
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        chk("same_issue_id", x_issue_id, 6);
        x_result_valid = 1'b1; x_result_id = 4'd1; x_result_data = 32'h00000111;
        #1 chk("same_rsp_valid", rsp_valid, 1);
        cyc();
        x_result_valid = 1'b0;
        chk("same_outstanding", outstanding_cnt, 3);
        cyc();

        // Drain remaining IDs out of order
        for (int k = 0; k < 3; k++) begin
            x_result_valid = 1'b1; x_result_id = drain_ids[k]; x_result_data = 32'hD0D0_0000 + 32'(k);
            #1;
            chk("drain_rsp_valid", rsp_valid, 1);
            chk("drain_rsp_id", rsp_id, 64'(drain_ids[k]));
            cyc();
        end
        x_result_valid = 1'b0;
        chk("drain_outstanding", outstanding_cnt, 0);

        // Unknown ID
        x_result_valid = 1'b1; x_result_id = 4'd7; x_result_data = 32'h00000777;
        #1 chk("unk_rsp_valid", rsp_valid, 0);
        cyc();
        x_result_valid = 1'b0;
        chk("unk_err", err_cnt, 1);
        chk("unk_outstanding", outstanding_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
